// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//
// Issue/writeback controller in front of the single-precision FPU core.
// It accepts one request at a time from execute, decodes funct7 into the
// FPU op, pulses fpu_start, waits for fpu_done with a timeout, and returns
// the result (or an error code) to writeback. A flush abandons the
// in-flight operation without producing a response.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   req_*           request handshake from execute (a, b, funct7, rd)
//   rsp_*           response handshake to writeback (data, rd, err)
//   flush           abandon the current request, no response
//   fpu_a/b/op      registered operands and op to the FPU
//   fpu_start       one-cycle start pulse to the FPU
//   fpu_done, fpu_r completion strobe and result from the FPU
//   busy            high whenever the controller is not idle
module fpu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic [1:0]  rsp_err,
    input  logic        flush,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_op,
    output logic        fpu_start,
    input  logic        fpu_done,
    input  logic [31:0] fpu_r,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    localparam logic [31:0]      CANON_NAN = 32'h7FC0_0000;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       ERR_OK      = 2'b00;
    localparam logic [1:0]       ERR_ILLEGAL = 2'b01;
    localparam logic [1:0]       ERR_TIMEOUT = 2'b10;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [1:0]       dec_op;
    logic             dec_legal;
    logic             timeout_hit;

    always_comb begin
        dec_op    = 2'b00;
        dec_legal = 1'b1;
        case (req_funct7)
            7'b0000000: dec_op = 2'b00;   // FADD.S
            7'b0000100: dec_op = 2'b01;   // FSUB.S
            7'b0001000: dec_op = 2'b10;   // FMUL.S
            default:    dec_legal = 1'b0;
        endcase
    end

    assign timeout_hit = (counter == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            counter   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_err   <= ERR_OK;
            fpu_a     <= '0;
            fpu_b     <= '0;
            fpu_op    <= 2'b00;
            fpu_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fpu_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        fpu_a     <= req_a;
                        fpu_b     <= req_b;
                        fpu_op    <= dec_op;
                        rsp_rd    <= req_rd;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (dec_legal) begin
                            state     <= ISSUE;
                            fpu_start <= 1'b1;
                        end else begin
                            // Illegal op never reaches the FPU; answer at once.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= CANON_NAN;
                            rsp_err   <= ERR_ILLEGAL;
                        end
                    end
                end
                ISSUE: begin
                    // The start pulse is already on the wire, so a flush
                    // here still has to wait out the FPU in DRAIN.
                    counter <= '0;
                    state   <= flush ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (flush) begin
                        // Flush beats a coincident done. A flush landing on
                        // the last timeout cycle also returns straight to
                        // IDLE so the counter never runs past its limit.
                        if (fpu_done || timeout_hit) begin
                            state     <= IDLE;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state   <= DRAIN;
                            counter <= counter + 1'b1;
                        end
                    end else if (fpu_done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= fpu_r;
                        rsp_err   <= ERR_OK;
                    end else if (timeout_hit) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= CANON_NAN;
                        rsp_err   <= ERR_TIMEOUT;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                DRAIN: begin
                    if (fpu_done || timeout_hit) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                RESP: begin
                    if (flush || rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed testbench for fpu_issue_ctrl with a small FPU stub.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [1:0]  rsp_err;
    logic        flush;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [1:0]  fpu_op;
    logic        fpu_start;
    logic        fpu_done;
    logic [31:0] fpu_r;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // FPU stub: results queued by the stimulus, returned model_lat cycles
    // after a start pulse; model_lat == 0 means the FPU never answers.
    int          model_lat = 0;
    int          cd = 0;
    logic        model_done;
    logic        man_done;
    logic [31:0] cur_res = 32'h0;
    logic [31:0] res_q[$];
    int          start_cnt = 0;

    assign fpu_done = model_done | man_done;
    assign fpu_r    = cur_res;

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_funct7(req_funct7), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .flush(flush),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_start(fpu_start),
        .fpu_done(fpu_done), .fpu_r(fpu_r),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            model_done <= 1'b0;
            cd         <= 0;
        end else begin
            model_done <= 1'b0;
            if (fpu_start) start_cnt <= start_cnt + 1;
            if (fpu_start && model_lat > 0) begin
                cd <= model_lat;
                if (res_q.size() > 0) cur_res <= res_q.pop_front();
            end else if (cd > 0) begin
                cd <= cd - 1;
                if (cd == 1) model_done <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a request for one cycle while req_ready is high; returns at
    // the negedge just after the accepting edge.
    task automatic issue_req(input logic [31:0] a, input logic [31:0] b,
                             input logic [6:0] f7, input logic [4:0] rd);
        req_a = a; req_b = b; req_funct7 = f7; req_rd = rd; req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, rsp_valid}, 32'd1);
    endtask

    int n;
    int s0;
    int got;
    logic acc2;
    logic [31:0] data_seen[2];
    logic [4:0]  rd_seen[2];

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_funct7 = '0;
        req_rd = '0; rsp_ready = 1'b1; flush = 1'b0; man_done = 1'b0;
        step(3);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_fpu_start", {31'b0, fpu_start}, 32'd0);
        chk("rst_rsp_data",  rsp_data,           32'h0);
        chk("rst_rsp_err",   {30'b0, rsp_err},   32'd0);
        chk("rst_fpu_a",     fpu_a,              32'h0);
        rst = 1'b1;
        step(1);

        // FADD 1.0 + 2.0, FPU latency 6
        s0 = start_cnt; model_lat = 6; res_q.push_back(32'h4040_0000);
        issue_req(32'h3F80_0000, 32'h4000_0000, 7'b0000000, 5'd5);
        chk("fadd_start",     {31'b0, fpu_start}, 32'd1);
        chk("fadd_op",        {30'b0, fpu_op},    32'd0);
        chk("fadd_fpu_a",     fpu_a,              32'h3F80_0000);
        chk("fadd_fpu_b",     fpu_b,              32'h4000_0000);
        chk("fadd_req_ready", {31'b0, req_ready}, 32'd0);
        chk("fadd_busy",      {31'b0, busy},      32'd1);
        wait_rsp("fadd_rsp_seen", n);
        chk("fadd_latency",   n,                  32'd8);
        chk("fadd_data",      rsp_data,           32'h4040_0000);
        chk("fadd_rd",        {27'b0, rsp_rd},    32'd5);
        chk("fadd_err",       {30'b0, rsp_err},   32'd0);
        step(1);
        chk("fadd_rsp_done",  {31'b0, rsp_valid}, 32'd0);
        chk("fadd_idle",      {31'b0, req_ready}, 32'd1);
        chk("fadd_starts",    start_cnt - s0,     32'd1);

        // FMUL 2.0 * 3.0 with writeback backpressure
        rsp_ready = 1'b0; res_q.push_back(32'h40C0_0000);
        issue_req(32'h4000_0000, 32'h4040_0000, 7'b0001000, 5'd12);
        chk("fmul_op", {30'b0, fpu_op}, 32'd2);
        wait_rsp("fmul_rsp_seen", n);
        for (int i = 0; i < 4; i++) begin
            chk("fmul_hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("fmul_hold_data",  rsp_data,           32'h40C0_0000);
            chk("fmul_hold_rd",    {27'b0, rsp_rd},    32'd12);
            chk("fmul_hold_ready", {31'b0, req_ready}, 32'd0);
            step(1);
        end
        rsp_ready = 1'b1;
        step(1);
        chk("fmul_rsp_done", {31'b0, rsp_valid}, 32'd0);
        chk("fmul_idle",     {31'b0, req_ready}, 32'd1);

        // Illegal funct7: immediate error response, FPU untouched
        s0 = start_cnt;
        issue_req(32'h1111_1111, 32'h2222_2222, 7'b0101100, 5'd7);
        chk("ill_valid", {31'b0, rsp_valid}, 32'd1);
        chk("ill_err",   {30'b0, rsp_err},   32'd1);
        chk("ill_data",  rsp_data,           32'h7FC0_0000);
        chk("ill_rd",    {27'b0, rsp_rd},    32'd7);
        chk("ill_start", {31'b0, fpu_start}, 32'd0);
        step(1);
        chk("ill_idle",   {31'b0, req_ready}, 32'd1);
        chk("ill_starts", start_cnt - s0,     32'd0);

        // Timeout: FPU never answers, 8 cycles in WAIT
        model_lat = 0;
        issue_req(32'h3F80_0000, 32'h3F80_0000, 7'b0000000, 5'd3);
        chk("to_start", {31'b0, fpu_start}, 32'd1);
        step(8);
        chk("to_not_yet", {31'b0, rsp_valid}, 32'd0);
        step(1);
        chk("to_valid", {31'b0, rsp_valid}, 32'd1);
        chk("to_err",   {30'b0, rsp_err},   32'd2);
        chk("to_data",  rsp_data,           32'h7FC0_0000);
        step(1);
        chk("to_idle",  {31'b0, req_ready}, 32'd1);
        // Next request proceeds normally
        model_lat = 2; res_q.push_back(32'h4000_0000);
        issue_req(32'h4040_0000, 32'h3F80_0000, 7'b0000100, 5'd4);
        chk("after_to_op", {30'b0, fpu_op}, 32'd1);
        wait_rsp("after_to_seen", n);
        chk("after_to_data", rsp_data,         32'h4000_0000);
        chk("after_to_err",  {30'b0, rsp_err}, 32'd0);
        step(1);

        // Flush in WAIT, done 3 cycles later: no response
        model_lat = 0;
        issue_req(32'h3F80_0000, 32'h3F80_0000, 7'b0000000, 5'd6);
        step(1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("fl_drain_busy",  {31'b0, busy},      32'd1);
        chk("fl_drain_valid", {31'b0, rsp_valid}, 32'd0);
        step(2);
        man_done = 1'b1;
        chk("fl_drain_busy2", {31'b0, busy},      32'd1);
        step(1);
        man_done = 1'b0;
        chk("fl_done_busy",   {31'b0, busy},      32'd0);
        chk("fl_done_valid",  {31'b0, rsp_valid}, 32'd0);
        chk("fl_done_ready",  {31'b0, req_ready}, 32'd1);

        // Flush coincident with done: flush wins
        issue_req(32'h3F80_0000, 32'h3F80_0000, 7'b0000000, 5'd8);
        step(2);
        flush = 1'b1; man_done = 1'b1;
        step(1);
        flush = 1'b0; man_done = 1'b0;
        chk("flc_busy",  {31'b0, busy},      32'd0);
        chk("flc_valid", {31'b0, rsp_valid}, 32'd0);
        step(1);
        chk("flc_valid2", {31'b0, rsp_valid}, 32'd0);

        // Back-to-back FSUB: 1.0-1.0 then 3.0-1.0
        model_lat = 3; s0 = start_cnt; rsp_ready = 1'b1;
        res_q.push_back(32'h0000_0000); res_q.push_back(32'h4000_0000);
        req_a = 32'h3F80_0000; req_b = 32'h3F80_0000; req_funct7 = 7'b0000100;
        req_rd = 5'd1; req_valid = 1'b1;
        step(1);
        req_a = 32'h4040_0000; req_rd = 5'd2;
        got = 0; acc2 = 1'b0;
        for (int i = 0; i < 60 && got < 2; i++) begin
            @(negedge clk);
            if (acc2) req_valid = 1'b0;
            if (req_ready && req_valid) acc2 = 1'b1;
            if (rsp_valid) begin
                data_seen[got] = rsp_data;
                rd_seen[got]   = rsp_rd;
                got++;
            end
        end
        req_valid = 1'b0;
        chk("b2b_count", got, 32'd2);
        chk("b2b_data0", data_seen[0],          32'h0000_0000);
        chk("b2b_rd0",   {27'b0, rd_seen[0]},   32'd1);
        chk("b2b_data1", data_seen[1],          32'h4000_0000);
        chk("b2b_rd1",   {27'b0, rd_seen[1]},   32'd2);
        step(2);
        chk("b2b_starts", start_cnt - s0, 32'd2);

        // Reset mid-WAIT
        model_lat = 0;
        issue_req(32'h1234_5678, 32'h9ABC_DEF0, 7'b0001000, 5'd9);
        step(2);
        rst = 1'b0;
        step(1);
        chk("mrst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("mrst_busy",      {31'b0, busy},      32'd0);
        chk("mrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mrst_rsp_data",  rsp_data,           32'h0);
        chk("mrst_rsp_rd",    {27'b0, rsp_rd},    32'd0);
        chk("mrst_fpu_a",     fpu_a,              32'h0);
        chk("mrst_fpu_b",     fpu_b,              32'h0);
        chk("mrst_fpu_op",    {30'b0, fpu_op},    32'd0);
        chk("mrst_fpu_start", {31'b0, fpu_start}, 32'd0);
        rst = 1'b1;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
